// File: rtl/pes_counter_pkg.sv
// Shared definitions for the sweep controller and its up/down counter datapath.
package pes_counter_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefCycw  = 4;

  localparam logic DirUp   = 1'b1;
  localparam logic DirDown = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2
  } state_t;

endpackage

// File: rtl/pes_updown_counter.sv
// Loadable up/down counter with enable; load wins over a count step.
module pes_updown_counter
  import pes_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= (UpOrDown == DirUp) ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign Count = r_count;

endmodule

// File: rtl/pes_sweep_ctrl.sv
// Triangle sweep controller: drives the up/down counter between latched bounds
// for a programmed number of cycles, with busy/done/err handshake.
module pes_sweep_ctrl
  import pes_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CYCW  = DefCycw
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYCW-1:0]  n_cycles,
  input  logic             step_en,
  output logic [WIDTH-1:0] Count,
  output logic             UpOrDown,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYCW-1:0]  cycles_done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CYCW-1:0]  r_n;
  logic [CYCW-1:0]  r_cycles;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_start_ok;
  logic             w_step;
  logic             w_cnt_dir;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [CYCW-1:0]  w_cyc_inc;

  assign w_start_ok = (r_state == StIdle) && start && (lo < hi);
  // abort beats a same-cycle step so the frozen Count matches the pre-abort value
  assign w_step     = (r_state != StIdle) && step_en && !abort;
  assign w_cnt_dir  = (r_state == StUp) ? DirUp : DirDown;
  assign w_inc      = Count + WIDTH'(1);
  assign w_dec      = Count - WIDTH'(1);
  assign w_cyc_inc  = r_cycles + CYCW'(1);

  pes_updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .Clk      (Clk),
    .reset    (reset),
    .load     (w_start_ok),
    .load_val (lo),
    .en       (w_step),
    .UpOrDown (w_cnt_dir),
    .Count    (Count)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_lo     <= '0;
      r_hi     <= '0;
      r_n      <= '0;
      r_cycles <= '0;
      r_dir    <= DirUp;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (lo < hi) begin
              r_lo     <= lo;
              r_hi     <= hi;
              r_n      <= n_cycles;
              r_cycles <= '0;
              r_dir    <= DirUp;
              r_busy   <= 1'b1;
              r_state  <= StUp;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        StUp: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (step_en && (w_inc == r_hi)) begin
            r_dir   <= DirDown;
            r_state <= StDown;
          end
        end
        StDown: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (step_en && (w_dec == r_lo)) begin
            r_cycles <= w_cyc_inc;
            if ((r_n != '0) && (w_cyc_inc == r_n)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_dir   <= DirUp;
              r_state <= StUp;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign UpOrDown    = r_dir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign cycles_done = r_cycles;

endmodule

// File: tb/tb_pes_sweep_ctrl.sv
// Self-checking bench for pes_sweep_ctrl: vector table, directed corner cases,
// then random stimulus against a step-count based triangle model.
module tb_pes_sweep_ctrl;

  logic       Clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] n_cycles;
  logic       step_en;
  logic [3:0] Count;
  logic       UpOrDown;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cycles_done;

  int checks = 0;
  int errors = 0;

  pes_sweep_ctrl #(
    .WIDTH (4),
    .CYCW  (4)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .lo          (lo),
    .hi          (hi),
    .n_cycles    (n_cycles),
    .step_en     (step_en),
    .Count       (Count),
    .UpOrDown    (UpOrDown),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cycles_done (cycles_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: position in the sweep is just the number of accepted steps since start.
  int m_busy, m_steps, m_lo, m_hi, m_n, m_cnt, m_dir, m_done, m_err, m_cyc;

  task automatic model_reset();
    m_busy = 0; m_steps = 0; m_lo = 0; m_hi = 0; m_n = 0;
    m_cnt = 0; m_dir = 1; m_done = 0; m_err = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    int span, pos;
    if (reset) begin
      model_reset();
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_busy == 0) begin
        if (start) begin
          if (lo < hi) begin
            m_busy = 1; m_steps = 0; m_lo = int'(lo); m_hi = int'(hi); m_n = int'(n_cycles);
            m_cnt = m_lo; m_dir = 1; m_cyc = 0;
          end else begin
            m_done = 1;
            m_err  = 1;
          end
        end
      end else if (abort) begin
        m_busy = 0;
      end else if (step_en) begin
        m_steps++;
        span  = m_hi - m_lo;
        pos   = m_steps % (2 * span);
        m_cnt = m_lo + ((pos <= span) ? pos : 2 * span - pos);
        m_dir = (pos < span) ? 1 : 0;
        m_cyc = (m_steps / (2 * span)) % 16;
        if (m_n != 0 && m_steps == m_n * 2 * span) begin
          m_busy = 0;
          m_done = 1;
          m_dir  = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count", int'(Count), m_cnt);
    check("updown", int'(UpOrDown), m_dir);
    check("busy", int'(busy), m_busy);
    check("done", int'(done), m_done);
    check("err", int'(err), m_err);
    check("cycles_done", int'(cycles_done), m_cyc);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic s, input logic a, input int l, input int h, input int n,
                       input logic st);
    start = s; abort = a; lo = 4'(l); hi = 4'(h); n_cycles = 4'(n); step_en = st;
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] n;
    logic       step;
    logic [3:0] e_cnt;
    logic       e_dir;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic [3:0] e_cyc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int strobes;
    bit seen;

    //          st ab lo hi n  se  cnt dir bsy dn er cyc
    vecs[0]  = '{1, 0, 2, 5, 1, 0,  2, 1, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 2, 5, 1, 1,  3, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 2, 5, 1, 1,  4, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 2, 5, 1, 1,  5, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 2, 5, 1, 1,  4, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 2, 5, 1, 1,  3, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 2, 5, 1, 1,  2, 0, 0, 1, 0, 1};
    vecs[7]  = '{0, 0, 2, 5, 1, 0,  2, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 0, 5, 5, 1, 0,  2, 0, 0, 1, 1, 1};
    vecs[9]  = '{0, 0, 5, 5, 1, 0,  2, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 1, 1, 3, 2, 0,  1, 1, 1, 0, 0, 0};
    vecs[11] = '{0, 1, 1, 3, 2, 1,  1, 1, 0, 0, 0, 0};

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].start, vecs[i].abort, int'(vecs[i].lo), int'(vecs[i].hi),
            int'(vecs[i].n), vecs[i].step);
      @(posedge Clk);
      model_step();
      #1;
      check($sformatf("vec%0d_count", i), int'(Count), int'(vecs[i].e_cnt));
      check($sformatf("vec%0d_dir", i), int'(UpOrDown), int'(vecs[i].e_dir));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e_err));
      check($sformatf("vec%0d_cyc", i), int'(cycles_done), int'(vecs[i].e_cyc));
    end

    // Continuous full-range sweep, then abort with a simultaneous step
    drive(1, 0, 0, 15, 0, 0);
    tick();
    for (int i = 0; i < 70; i++) begin
      drive(0, 0, 0, 15, 0, 1);
      tick();
      if (i == 29) check("cont_cyc_after30", int'(cycles_done), 1);
      if (i == 59) check("cont_cyc_after60", int'(cycles_done), 2);
    end
    drive(0, 1, 0, 15, 0, 1);
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(Count), 10);
    check("abort_done", int'(done), 0);
    drive(0, 0, 0, 15, 0, 0);
    tick();
    check("abort_no_late_done", int'(done), 0);

    // Toggling strobe: done after exactly 8 strobes
    drive(1, 0, 1, 3, 2, 0);
    tick();
    strobes = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(0, 0, 1, 3, 2, (i % 2) == 0);
      tick();
      if (step_en) strobes++;
      if (done) begin
        seen = 1;
        check("toggle_strobes", strobes, 8);
      end
    end
    check("toggle_done_seen", int'(seen), 1);

    // Start pulsed mid-sweep with new bounds is ignored
    drive(1, 0, 2, 6, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2, 6, 1, 1);
      tick();
    end
    drive(1, 0, 0, 9, 3, 1);
    tick();
    check("midstart_count", int'(Count), 6);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive(0, 0, 0, 9, 3, 1);
      tick();
      if (done) begin
        seen = 1;
        check("midstart_end_count", int'(Count), 2);
        check("midstart_cyc", int'(cycles_done), 1);
      end
    end
    check("midstart_done_seen", int'(seen), 1);

    // Asynchronous reset in the DOWN leg
    drive(1, 0, 3, 7, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 3, 7, 0, 1);
      tick();
    end
    drive(0, 0, 3, 7, 0, 0);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    check("arst_count", int'(Count), 0);
    check("arst_dir", int'(UpOrDown), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_cyc", int'(cycles_done), 0);
    model_reset();
    tick();
    @(negedge Clk);
    reset = 1'b0;
    drive(1, 0, 2, 4, 1, 0);
    tick();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(0, 0, 2, 4, 1, 1);
      tick();
      if (done) seen = 1;
    end
    check("post_reset_done_seen", int'(seen), 1);

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pes_sweep_ctrl.md
# pes_sweep_ctrl

Sweep controller for the 4-bit up/down counter datapath. It turns a start command with programmable lower/upper bounds and a repeat count into a triangle sequence: count up from `lo` to `hi`, back down to `lo`, and repeat. Every step is qualified by an external `step_en` strobe. It owns the counter's direction, load and enable. It reports progress upward with a busy/done handshake and a completed-cycle count.

## Interface
- `WIDTH`, 4, counter width.
- `CYCW`, 4, width of the repeat-count and cycle-counter fields.

- `Clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch request; sampled only in IDLE.
- `abort` in 1: stop an active sweep.
- `lo` in WIDTH: lower bound, captured on accepted start.
- `hi` in WIDTH: upper bound, captured on accepted start.
- `n_cycles` in CYCW: number of full up+down cycles. 0 = run continuously until abort.
- `step_en` in 1: advance the counter one step this cycle.
- `Count` out WIDTH: current counter value.
- `UpOrDown` out 1: 1 = counting up, 0 = counting down.
- `busy` out 1: sweep active.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse alongside `done` when bounds are invalid.
- `cycles_done` out CYCW: completed cycles in the current or last sweep.

## Operation
- Reset values:
  - `Count`=0, `UpOrDown`=1, `busy`=0, `done`=0, `err`=0, `cycles_done`=0.
  - State = IDLE.
- FSM states: IDLE, UP, DOWN. `busy`=1 exactly in UP and DOWN.
- IDLE, start=1, captured `lo`<`hi`:
  - Latch `lo`, `hi`, `n_cycles`.
  - Set `Count`←`lo`, `cycles_done`←0, `UpOrDown`←1.
  - Go to UP.
- IDLE, start=1, `lo`≥`hi`:
  - Stay in IDLE; `Count` unchanged.
  - Pulse `done` and `err` together for one cycle.
- IDLE with start=0: `Count` and `UpOrDown` hold their last values.
- UP, step_en=1:
  - `Count`←`Count`+1.
  - If `Count`+1 == latched `hi`: go to DOWN and set `UpOrDown`←0.
- DOWN, step_en=1:
  - `Count`←`Count`−1.
  - If `Count`−1 == latched `lo`, the cycle is complete and `cycles_done`←`cycles_done`+1.
  - On completion, if `n_cycles`≠0 and the new `cycles_done` == `n_cycles`: go to IDLE and pulse `done`.
  - Otherwise go to UP with `UpOrDown`←1.
- step_en=0: `Count`, state and `UpOrDown` hold.
- Sequence shape:
  - Each `hi` turnaround value appears once per cycle.
  - `lo` appears once per boundary.
  - Period = 2·(`hi`−`lo`) steps.
- Continuous mode (`n_cycles`=0): `cycles_done` wraps modulo 2^CYCW. `done` never pulses.
- abort in UP/DOWN:
  - Go to IDLE on the next edge with no `done` pulse.
  - `Count` and `cycles_done` freeze.
  - abort takes priority over a step_en in the same cycle.
- abort in IDLE is ignored. A simultaneous start is still accepted.
- start while busy is ignored. Changes to `lo`, `hi`, `n_cycles` while busy are ignored.
- Arithmetic is unsigned WIDTH-bit. Valid bounds (`lo`<`hi`) guarantee no wrap; `Count` never leaves [`lo`, `hi`] while busy.
- `reset` mid-sweep forces all reset values asynchronously. No `done` is issued.

## Timing
- All outputs are registered.
- Accepted start sampled at edge k: `busy`=1 and `Count`=`lo` after edge k.
- Each step_en sampled at an edge updates `Count` after that same edge. Latency is one cycle from strobe to value.
- Final step at edge m: after edge m, `Count`=`lo`, `busy`=0, `done`=1. `done` deasserts after edge m+1.
- Bad-bounds start at edge k: `done`=`err`=1 during cycle k+1 only.
- A new start is accepted in the cycle `done` is high; that is already IDLE.

## Structure
- Shared package `pes_counter_pkg`:
  - FSM state encoding (IDLE/UP/DOWN).
  - Default WIDTH/CYCW constants.
  - The UP/DOWN direction constants (1/0).
- One sub-module, `pes_updown_counter`: loadable up/down counter with enable.
  - Inputs: `Clk`, `reset`, `load`, `load_val`, `en`, `UpOrDown`.
  - Output: `Count`.
- The FSM, bound latches and cycle counter live in `pes_sweep_ctrl`.

## Test plan
- lo=2, hi=5, n=1, step_en held 1:
  - `Count` runs 2,3,4,5,4,3,2 on consecutive cycles.
  - `UpOrDown` falls when `Count` reaches 5.
  - `done` pulses one cycle with `Count`=2; `cycles_done`=1; `busy`=0.
- lo=5, hi=5 start: `done`=`err`=1 for one cycle, `busy` stays 0, `Count` unchanged.
- lo=0, hi=15, n=0, 70 steps:
  - `cycles_done` increments every 30 steps.
  - abort with step_en=1 the same cycle: `busy`=0 next cycle, `Count` frozen, no `done`.
- lo=1, hi=3, n=2, step_en toggling 1/0: `Count` holds during 0 cycles; `done` after 8 strobes.
- start pulsed mid-sweep with new lo/hi values: sweep continues with the original bounds and cycle count.
- reset asserted mid-DOWN: all outputs take reset values immediately (asynchronously). After release, a fresh start behaves normally.
